// File: rtl/arm_hazard_pkg.sv
// Shared types and constants for the ARM pipeline hazard controller.
//   fwd_sel_t   : per-source forwarding select driven onto ForwardE
//   mem_state_t : data-memory wait FSM state
//   PC_REG      : architectural register number of the PC (never forwarded)
package arm_hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        MS_IDLE = 1'b0,
        MS_WAIT = 1'b1
    } mem_state_t;

    localparam int PC_REG = 15;

endpackage

// File: rtl/arm_hazard_unit_shadow.sv
// hazard_shadow_reg: one stage of the hazard unit's private copy of the pipe.
//   clk, rst_n : clock, asynchronous active-low reset (clears to a bubble)
//   en         : advance this stage (low = hold)
//   clr        : when advancing, load a bubble instead of d
//   d, q       : packed stage fields in / out
module hazard_shadow_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= clr ? '0 : d;
        end
    end

endmodule

// File: rtl/arm_hazard_unit.sv
// arm_hazard_unit: forwarding, stall and flush controller for the 5-stage
// ARM pipeline. It keeps a shadow copy of the E/M/W destination state, so
// only decode-time information has to be supplied by the core.
//   clk, reset     : clock, asynchronous active-low reset
//   RAD, SrcValidD : decode source register numbers and their valid bits
//   WA3D, RegWriteD, MemToRegD, MemReqD, PCSrcD : decode instruction info
//   BranchTakenE   : branch resolved taken in execute
//   ForwardE       : per-source select (00 regfile, 01 ResultW, 10 ALUOutM)
//   StallF/D/E/M   : hold the corresponding pipe register
//   FlushD/E       : bubble into D / E
//   MemBusy        : data-memory wait FSM is in WAIT (FSM state visibility)
module arm_hazard_unit
    import arm_hazard_pkg::*;
#(
    parameter int REG_AW   = 4,
    parameter int NUM_SRC  = 3,
    parameter int MEM_WAIT = 0,
    parameter int FWD_EN   = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_SRC*REG_AW-1:0]   RAD,
    input  logic [NUM_SRC-1:0]          SrcValidD,
    input  logic [REG_AW-1:0]           WA3D,
    input  logic                        RegWriteD,
    input  logic                        MemToRegD,
    input  logic                        MemReqD,
    input  logic                        PCSrcD,
    input  logic                        BranchTakenE,
    output logic [2*NUM_SRC-1:0]        ForwardE,
    output logic                        StallF,
    output logic                        StallD,
    output logic                        StallE,
    output logic                        StallM,
    output logic                        FlushD,
    output logic                        FlushE,
    output logic                        MemBusy
);

    localparam int E_W = NUM_SRC*REG_AW + NUM_SRC + REG_AW + 4;
    localparam int M_W = REG_AW + 3;
    localparam int W_W = REG_AW + 2;
    localparam int CW  = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
    localparam logic [CW-1:0]     CNT_LOAD = CW'((MEM_WAIT > 0) ? MEM_WAIT - 1 : 0);
    localparam logic [REG_AW-1:0] PC_ADDR  = REG_AW'(PC_REG);

    // Shadow stage fields
    logic [NUM_SRC*REG_AW-1:0] ra_e;
    logic [NUM_SRC-1:0]        src_valid_e;
    logic [REG_AW-1:0]         wa3_e, wa3_m, wa3_w;
    logic reg_write_e, mem_to_reg_e, mem_req_e, pc_src_e;
    logic reg_write_m, mem_req_m, pc_src_m;
    logic reg_write_w, pc_src_w;

    logic [E_W-1:0] e_q;
    logic [M_W-1:0] m_q;
    logic [W_W-1:0] w_q;

    // Hazard terms
    logic                 mem_stall;
    logic                 ldr_stall;
    logic                 pc_pend;
    logic                 flush_e_int;
    logic [NUM_SRC-1:0]   ld_hit;
    logic [NUM_SRC-1:0]   raw_hit;
    logic [2*NUM_SRC-1:0] fwd_int;

    // Memory wait FSM
    mem_state_t    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    // E freezes only for memory wait; ldr/branch bubbles enter when it advances.
    hazard_shadow_reg #(.W(E_W)) u_shadow_e (
        .clk   (clk),
        .rst_n (reset),
        .en    (!mem_stall),
        .clr   (flush_e_int),
        .d     ({RAD, SrcValidD, WA3D, RegWriteD, MemToRegD, MemReqD, PCSrcD}),
        .q     (e_q)
    );

    hazard_shadow_reg #(.W(M_W)) u_shadow_m (
        .clk   (clk),
        .rst_n (reset),
        .en    (!mem_stall),
        .clr   (1'b0),
        .d     ({wa3_e, reg_write_e, mem_req_e, pc_src_e}),
        .q     (m_q)
    );

    // W holds alongside M so its forwarding value stays valid during a wait.
    hazard_shadow_reg #(.W(W_W)) u_shadow_w (
        .clk   (clk),
        .rst_n (reset),
        .en    (!mem_stall),
        .clr   (1'b0),
        .d     ({wa3_m, reg_write_m, pc_src_m}),
        .q     (w_q)
    );

    assign {ra_e, src_valid_e, wa3_e, reg_write_e, mem_to_reg_e, mem_req_e, pc_src_e} = e_q;
    assign {wa3_m, reg_write_m, mem_req_m, pc_src_m} = m_q;
    assign {wa3_w, reg_write_w, pc_src_w} = w_q;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic [REG_AW-1:0] ra_e_i;
        logic [REG_AW-1:0] ra_d_i;
        logic              use_d;
        fwd_sel_t          sel;

        assign ra_e_i = ra_e[i*REG_AW +: REG_AW];
        assign ra_d_i = RAD[i*REG_AW +: REG_AW];
        // Reading R15 yields PC+8 from fetch, so it never depends on a writer.
        assign use_d  = SrcValidD[i] && (ra_d_i != PC_ADDR);

        // M is the younger writer, so it takes priority over W.
        always_comb begin
            sel = FWD_RF;
            if (FWD_EN != 0 && src_valid_e[i] && ra_e_i != PC_ADDR) begin
                if (reg_write_m && wa3_m == ra_e_i) begin
                    sel = FWD_M;
                end else if (reg_write_w && wa3_w == ra_e_i) begin
                    sel = FWD_W;
                end
            end
        end

        assign fwd_int[2*i +: 2] = sel;
        assign ld_hit[i]  = use_d && mem_to_reg_e && reg_write_e && (wa3_e == ra_d_i);
        assign raw_hit[i] = use_d && ((reg_write_e && wa3_e == ra_d_i) ||
                                      (reg_write_m && wa3_m == ra_d_i));
    end

    // Without forwarding every RAW dependency on E or M has to wait instead.
    assign ldr_stall = (|ld_hit) || (FWD_EN == 0 && (|raw_hit));
    assign pc_pend   = PCSrcD | pc_src_e | pc_src_m;
    assign flush_e_int = !mem_stall && (ldr_stall || BranchTakenE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= MS_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // The entry cycle stalls from IDLE, then WAIT stalls until cnt hits 0;
    // the cnt==0 cycle is the release cycle on which M advances.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mem_stall = 1'b0;
        case (state)
            MS_IDLE: begin
                if (MEM_WAIT > 0 && mem_req_m) begin
                    mem_stall = 1'b1;
                    state_nxt = MS_WAIT;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            MS_WAIT: begin
                if (cnt != '0) begin
                    mem_stall = 1'b1;
                    cnt_nxt   = cnt - CW'(1);
                end else begin
                    state_nxt = MS_IDLE;
                end
            end
            default: begin
                state_nxt = MS_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Memory wait dominates: freeze everything and defer flushes to release.
    // All controls are forced low while reset is asserted.
    assign ForwardE = reset ? fwd_int : '0;
    assign StallF   = reset & (mem_stall | ldr_stall | pc_pend);
    assign StallD   = reset & (mem_stall | ldr_stall);
    assign StallE   = reset & mem_stall;
    assign StallM   = reset & mem_stall;
    assign FlushD   = reset & !mem_stall & (pc_pend | pc_src_w | BranchTakenE);
    assign FlushE   = reset & flush_e_int;
    assign MemBusy  = reset & (state == MS_WAIT);

endmodule

// File: tb/tb_arm_hazard_unit.sv
// Bench for arm_hazard_unit: two instances (MEM_WAIT=0 and MEM_WAIT=2) share
// one stimulus stream; a per-instance instruction-level model predicts
// every output each cycle, plus directed constant checks.
module tb_arm_hazard_unit;

    typedef struct packed {
        logic [3:0]  wa;
        logic        rw;
        logic        mtr;
        logic        mreq;
        logic        pcs;
        logic [11:0] ra;
        logic [2:0]  sv;
    } instr_t;

    logic   clk = 1'b0;
    logic   reset;
    logic   br;
    instr_t d_in;

    logic [5:0] fwd0, fwd2;
    logic sf0, sd0, se0, sm0, fd0, fe0, busy0;
    logic sf2, sd2, se2, sm2, fd2, fe2, busy2;
    logic [12:0] obs0, obs2;

    int tests = 0;
    int fails = 0;

    // Model state per instance: instruction in E/M/W and cycles spent in M.
    instr_t      me[2], mm[2], mw[2];
    int          m_age[2];
    int          mem_wait_of[2];
    logic [12:0] exp_v[2];
    logic        exp_ms[2], exp_fe[2];

    always #5 clk = ~clk;

    arm_hazard_unit #(.REG_AW(4), .NUM_SRC(3), .MEM_WAIT(0), .FWD_EN(1)) u_dut0 (
        .clk(clk), .reset(reset), .RAD(d_in.ra), .SrcValidD(d_in.sv), .WA3D(d_in.wa),
        .RegWriteD(d_in.rw), .MemToRegD(d_in.mtr), .MemReqD(d_in.mreq), .PCSrcD(d_in.pcs),
        .BranchTakenE(br), .ForwardE(fwd0), .StallF(sf0), .StallD(sd0), .StallE(se0),
        .StallM(sm0), .FlushD(fd0), .FlushE(fe0), .MemBusy(busy0)
    );

    arm_hazard_unit #(.REG_AW(4), .NUM_SRC(3), .MEM_WAIT(2), .FWD_EN(1)) u_dut2 (
        .clk(clk), .reset(reset), .RAD(d_in.ra), .SrcValidD(d_in.sv), .WA3D(d_in.wa),
        .RegWriteD(d_in.rw), .MemToRegD(d_in.mtr), .MemReqD(d_in.mreq), .PCSrcD(d_in.pcs),
        .BranchTakenE(br), .ForwardE(fwd2), .StallF(sf2), .StallD(sd2), .StallE(se2),
        .StallM(sm2), .FlushD(fd2), .FlushE(fe2), .MemBusy(busy2)
    );

    assign obs0 = {fwd0, sf0, sd0, se0, sm0, fd0, fe0, busy0};
    assign obs2 = {fwd2, sf2, sd2, se2, sm2, fd2, fe2, busy2};

    function automatic logic [12:0] pack(input logic [5:0] f, input logic sf, input logic sd,
                                         input logic se, input logic sm, input logic fd,
                                         input logic fe, input logic busy);
        return {f, sf, sd, se, sm, fd, fe, busy};
    endfunction

    function automatic instr_t mk(input int wa, input logic rw, input logic mtr,
                                  input logic mreq, input logic pcs, input int r0,
                                  input int r1, input logic [2:0] sv);
        instr_t t;
        t = '0;
        t.wa = 4'(wa); t.rw = rw; t.mtr = mtr; t.mreq = mreq; t.pcs = pcs;
        t.ra = {4'd0, 4'(r1), 4'(r0)};
        t.sv = sv;
        return t;
    endfunction

    task automatic check(input string tag, input logic [12:0] got, input logic [12:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%013b expected=%013b", tag, got, exp);
        end
    endtask

    // Predict outputs of instance k from the current inputs and model state.
    task automatic model_eval(input int k);
        logic       ms, ldr, pcp, busy;
        logic [5:0] fwd;
        ms   = (mem_wait_of[k] > 0) && mm[k].mreq && (m_age[k] < mem_wait_of[k]);
        busy = (mem_wait_of[k] > 0) && mm[k].mreq && (m_age[k] >= 1);
        ldr  = 1'b0;
        fwd  = '0;
        for (int i = 0; i < 3; i++) begin
            logic [3:0] rd, re;
            rd = d_in.ra[i*4 +: 4];
            re = me[k].ra[i*4 +: 4];
            if (d_in.sv[i] && rd != 4'd15 && me[k].rw && me[k].mtr && me[k].wa == rd) ldr = 1'b1;
            if (me[k].sv[i] && re != 4'd15) begin
                if (mm[k].rw && mm[k].wa == re)      fwd[i*2 +: 2] = 2'b10;
                else if (mw[k].rw && mw[k].wa == re) fwd[i*2 +: 2] = 2'b01;
            end
        end
        pcp = d_in.pcs | me[k].pcs | mm[k].pcs;
        if (ms) exp_v[k] = pack(fwd, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, busy);
        else    exp_v[k] = pack(fwd, ldr | pcp, ldr, 1'b0, 1'b0, pcp | mw[k].pcs | br, ldr | br, busy);
        if (!reset) exp_v[k] = '0;
        exp_ms[k] = ms;
        exp_fe[k] = !ms && (ldr || br);
    endtask

    task automatic model_clock();
        for (int k = 0; k < 2; k++) begin
            if (!reset) begin
                me[k] = '0; mm[k] = '0; mw[k] = '0; m_age[k] = 0;
            end else if (!exp_ms[k]) begin
                mw[k] = mm[k];
                mm[k] = me[k];
                me[k] = exp_fe[k] ? '0 : d_in;
                m_age[k] = 0;
            end else begin
                m_age[k]++;
            end
        end
    endtask

    // Inputs are driven at the negedge; settle samples 1 time unit later.
    task automatic settle(input string tag);
        #1;
        model_eval(0);
        model_eval(1);
        check({tag, "/mw0"}, obs0, exp_v[0]);
        check({tag, "/mw2"}, obs2, exp_v[1]);
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic cycle(input string tag);
        settle(tag);
        tick();
    endtask

    logic sf_pat[5];
    logic fd_pat[5];
    logic [12:0] mw_pat[4];
    logic sm_pat[7];

    initial begin
        mem_wait_of[0] = 0;
        mem_wait_of[1] = 2;
        for (int k = 0; k < 2; k++) begin
            me[k] = '0; mm[k] = '0; mw[k] = '0; m_age[k] = 0;
        end
        reset = 1'b0;
        br    = 1'b1;
        d_in  = mk(3, 1, 0, 0, 1, 7, 9, 3'b111);

        // Reset held two cycles, noisy inputs: every output must stay 0
        @(negedge clk);
        settle("reset_a");
        check("reset_zero0", obs0, 13'd0);
        tick();
        d_in.ra = 12'(($urandom_range(0, 4095)));
        settle("reset_b");
        check("reset_zero2", obs2, 13'd0);
        tick();
        reset = 1'b1;
        br    = 1'b0;
        d_in  = '0;
        cycle("idle");

        // Forward priority: M beats W
        d_in = mk(1, 1, 0, 0, 0, 0, 0, 3'b000); cycle("fwd_a");
        d_in = mk(1, 1, 0, 0, 0, 0, 0, 3'b000); cycle("fwd_b");
        d_in = mk(2, 1, 0, 0, 0, 1, 1, 3'b011); cycle("fwd_c");
        d_in = '0; settle("fwd_d");
        check("fwd_m_prio", {obs0[12:7], 7'd0}, {6'b001010, 7'd0});
        tick();
        // Middle write removed: W supplies the value
        d_in = mk(1, 1, 0, 0, 0, 0, 0, 3'b000); cycle("fwdw_a");
        d_in = '0;                              cycle("fwdw_b");
        d_in = mk(2, 1, 0, 0, 0, 1, 1, 3'b011); cycle("fwdw_c");
        d_in = '0; settle("fwdw_d");
        check("fwd_w_only", {obs0[12:7], 7'd0}, {6'b000101, 7'd0});
        tick();
        // R15 is never forwarded
        d_in = mk(15, 1, 0, 0, 0, 0, 0, 3'b000); cycle("fwdpc_a");
        d_in = mk(15, 1, 0, 0, 0, 0, 0, 3'b000); cycle("fwdpc_b");
        d_in = mk(2, 1, 0, 0, 0, 15, 15, 3'b011); cycle("fwdpc_c");
        d_in = '0; settle("fwdpc_d");
        check("fwd_pc_never", {obs0[12:7], 7'd0}, 13'd0);
        tick();

        // Load-use: LDR R3 then SUB R4,R3,#1
        d_in = mk(3, 1, 1, 1, 0, 0, 0, 3'b000); cycle("ldr_a");
        d_in = mk(4, 1, 0, 0, 0, 3, 0, 3'b001); settle("ldr_b");
        check("ldr_stall", obs0, pack(6'd0, 1, 1, 0, 0, 0, 1, 0));
        tick();
        settle("ldr_c");
        check("ldr_release", obs0, 13'd0);
        tick();
        d_in = '0; settle("ldr_d");
        check("ldr_fwd_w", {obs0[12:7], 7'd0}, {6'b000001, 7'd0});
        tick();
        for (int i = 0; i < 6; i++) cycle("drain1");

        // Taken branch
        br = 1'b1; settle("br");
        check("branch_flush", obs0, pack(6'd0, 0, 0, 0, 0, 1, 1, 0));
        tick();
        br = 1'b0; cycle("br_after");

        // PC write: StallF for 3 cycles, FlushD for 4
        sf_pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        fd_pat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        d_in = mk(0, 0, 0, 0, 1, 0, 0, 3'b000);
        for (int i = 0; i < 5; i++) begin
            settle("pc");
            check("pc_stallf", {12'd0, obs0[6]}, {12'd0, sf_pat[i]});
            check("pc_flushd", {12'd0, obs0[2]}, {12'd0, fd_pat[i]});
            tick();
            d_in = '0;
        end

        // MEM_WAIT=2: load in M stalls two cycles, advances on the third
        mw_pat = '{pack(6'd0, 1, 1, 1, 1, 0, 0, 0), pack(6'd0, 1, 1, 1, 1, 0, 0, 1),
                   pack(6'd0, 0, 0, 0, 0, 0, 0, 1), 13'd0};
        d_in = mk(5, 1, 1, 1, 0, 0, 0, 3'b000); cycle("mw_a");
        d_in = '0;                              cycle("mw_b");
        for (int i = 0; i < 4; i++) begin
            settle("mw");
            check("memwait_window", obs2, mw_pat[i]);
            tick();
        end

        // Back-to-back stores: two stall windows split by one advance
        sm_pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        d_in = mk(0, 0, 0, 1, 0, 1, 2, 3'b011); cycle("str_a");
        d_in = mk(0, 0, 0, 1, 0, 1, 2, 3'b011); cycle("str_b");
        d_in = '0;
        for (int i = 0; i < 7; i++) begin
            settle("str");
            check("str_stallm", {12'd0, obs2[3]}, {12'd0, sm_pat[i]});
            tick();
        end

        // Reset asserted while WAIT with a taken branch pending
        d_in = mk(0, 0, 0, 1, 0, 0, 0, 3'b000); cycle("rw_a");
        d_in = '0; cycle("rw_b");
        cycle("rw_c");
        br = 1'b1; reset = 1'b0; settle("rw_d");
        check("rst_wait_now", obs2, 13'd0);
        tick();
        settle("rw_e");
        check("rst_wait_edge", obs2, 13'd0);
        tick();
        br = 1'b0; reset = 1'b1; settle("rw_f");
        check("rst_no_residual", obs2, 13'd0);
        check("rst_no_residual0", obs0, 13'd0);
        tick();

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            int r0, r1, r2;
            r0 = $urandom_range(0, 5); if (r0 == 5) r0 = 15;
            r1 = $urandom_range(0, 5); if (r1 == 5) r1 = 15;
            r2 = $urandom_range(0, 4);
            d_in      = mk($urandom_range(0, 4), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 9) == 0),
                           r0, r1, 3'($urandom_range(0, 7)));
            d_in.ra[11:8] = 4'(r2);
            br        = 1'($urandom_range(0, 7) == 0);
            reset     = !($urandom_range(0, 63) == 0);
            cycle("rand");
        end
        reset = 1'b1;
        br    = 1'b0;
        d_in  = '0;
        for (int i = 0; i < 4; i++) cycle("tail");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
